// File: rtl/page_arbiter.sv
// Page arbiter: owns the current TopState, validates page requests and sequences transitions.
// Optional blank-screen phase enabled by defining PAGE_ARB_BLANK_EN.
package page_arbiter_pkg;
  localparam int unsigned TEXT_CHARS = 16;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned ARROW_W    = 4;
  localparam int unsigned PIANO_W    = 12;

  localparam logic [STATE_W-1:0] ST_INIT = STATE_W'(0);
  localparam logic [ARROW_W-1:0] ARROW_RIGHT = 4'b0001;
  localparam logic [ARROW_W-1:0] ARROW_LEFT  = 4'b0010;
  localparam logic [ARROW_W-1:0] ARROW_DOWN  = 4'b0100;
  localparam logic [ARROW_W-1:0] ARROW_UP    = 4'b1000;

  typedef logic [TEXT_CHARS-1:0][7:0] text_t;
  localparam text_t BLANK_TEXT = {TEXT_CHARS{8'h20}};

  typedef struct packed {
    logic [PIANO_W-1:0] piano_keys;
    logic [ARROW_W-1:0] arrow_keys;
    logic               enter;
  } user_input_t;

  typedef struct packed {
    text_t              text;
    logic [STATE_W-1:0] state;
  } program_output_t;
endpackage

module page_arbiter
  import page_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PAGES   = 5,
  parameter int unsigned BLANK_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  user_input_t          user_in,
  input  program_output_t      page_out [NUM_PAGES],
  output user_input_t          user_in_gated,
  output logic [NUM_PAGES-1:0] page_en,
  output logic [NUM_PAGES-1:0] page_rst,
  output program_output_t      prog_out,
  output logic                 busy,
  output logic                 req_err
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_RUN, ST_BLANK, ST_ENTER} state_e;

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   cur_q, cur_d;
  logic [STATE_W-1:0]   nxt_q, nxt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 lock_q, lock_d;
  logic                 err_d;
  logic [STATE_W-1:0]   req_s;

  logic [NUM_PAGES-1:0] page_en_q;
  logic [NUM_PAGES-1:0] page_rst_q;
  program_output_t      prog_q;
  logic                 busy_q;
  logic                 req_err_q;

  // Next-state: request validation in RUN, blank countdown, one-cycle ENTER handoff
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    req_s   = page_out[cur_q].state;
    case (state_q)
      ST_RUN: begin
        if (tick && (req_s != cur_q)) begin
          if (32'(req_s) >= NUM_PAGES) begin
            err_d = 1'b1;
          end else begin
            nxt_d  = req_s;
            cnt_d  = CNT_W'(BLANK_TICKS - 1);
            lock_d = 1'b1;
`ifdef PAGE_ARB_BLANK_EN
            state_d = ST_BLANK;
`else
            state_d = ST_ENTER;
`endif
          end
        end
        // Lock releases only once the keys are seen idle on a tick with no new transition
        if (tick && (state_d == ST_RUN) && (user_in.arrow_keys == '0)) begin
          lock_d = 1'b0;
        end
      end
      ST_BLANK: begin
        if (tick) begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             state_d = ST_ENTER;
        end
      end
      ST_ENTER: begin
        cur_d   = nxt_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cur_q       <= ST_INIT;
      nxt_q       <= ST_INIT;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      page_en_q   <= NUM_PAGES'(1);
      page_rst_q  <= '0;
      busy_q      <= 1'b0;
      req_err_q   <= 1'b0;
      prog_q.text <= BLANK_TEXT;
      prog_q.state <= ST_INIT;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      page_en_q   <= NUM_PAGES'(1) << cur_d;
      page_rst_q  <= (state_d == ST_ENTER) ? (NUM_PAGES'(1) << nxt_d) : '0;
      busy_q      <= (state_d != ST_RUN);
      req_err_q   <= err_d;
      prog_q.text <= (state_q == ST_RUN) ? page_out[cur_q].text : BLANK_TEXT;
      prog_q.state <= cur_d;
    end
  end

  // Arrow keys are suppressed while a held key could cascade into the new page
  always_comb begin
    user_in_gated = user_in;
    if (lock_q) user_in_gated.arrow_keys = '0;
  end

  assign page_en  = page_en_q;
  assign page_rst = page_rst_q;
  assign prog_out = prog_q;
  assign busy     = busy_q;
  assign req_err  = req_err_q;
endmodule

// File: doc/page_arbiter.md
# page_arbiter

Top-level page controller for the piano UI. Every page module (init, menu, play modes, …) is always instantiated and proposes a `ProgramOutput` containing its screen text and its requested `TopState`. This block owns the authoritative current `TopState` and validates page-change requests. It sequences each transition (blank screen, reset the entering page, key lockout) and drives the single `ProgramOutput` that reaches the display.

## Interface
Parameters:
- `NUM_PAGES`, default 5: number of page modules; page *i* serves the `TopState` with numeric value *i*.
- `BLANK_TICKS`, default 4: ticks the screen stays blank during a transition; legal range 1..255.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: program-rate strobe, one `clk` cycle wide; all page-request sampling is tick-gated.
- `user_in`, in, `UserInput`: raw user input.
- `page_out`, in, `ProgramOutput [NUM_PAGES]`: per-page proposed text and state.
- `user_in_gated`, out, `UserInput`: input forwarded to all pages. Equals `user_in` except that `arrow_keys` is forced to 0 while locked out.
- `page_en`, out, `NUM_PAGES`: one-hot; the bit for the current page is set.
- `page_rst`, out, `NUM_PAGES`: one-`clk` pulse to the entering page.
- `prog_out`, out, `ProgramOutput`: registered display output.
- `busy`, out, 1: high while a transition is in progress.
- `req_err`, out, 1: one-`clk` pulse when a page requests an illegal state.

## Operation
- The FSM has three states: RUN, BLANK and ENTER. Registers are `cur`, `nxt`, the counter `cnt` (8 bits) and the flag `lock`.
- **RUN**
  - On `tick`, sample `r = page_out[cur].state`.
  - If `r == cur`: no action.
  - If `r >= NUM_PAGES`: pulse `req_err`; stay in RUN.
  - Otherwise: `nxt <= r`, `cnt <= BLANK_TICKS-1`, `lock <= 1`, go to BLANK.
- **BLANK**
  - `prog_out.text` shows all spaces (8'h20 per character).
  - On `tick` with `cnt != 0`: decrement `cnt`.
  - On `tick` with `cnt == 0`: go to ENTER.
  - Page requests are not sampled.
- **ENTER** (lasts exactly one `clk`, not tick-gated)
  - `page_rst[nxt] = 1`.
  - `cur <= nxt`.
  - Go to RUN.
- **`prog_out`** is registered every `clk`:
  - In RUN: `text = page_out[cur].text`.
  - In BLANK and ENTER: text is blank.
  - `prog_out.state = cur` at all times.
- **`busy`** is 1 in BLANK and ENTER, 0 in RUN.
- **`page_en`** equals `1 << cur`. It switches in the same cycle that `cur` updates.
- **Key lockout**
  - `lock` is set when a transition starts.
  - It clears on the first `tick` in RUN where `user_in.arrow_keys == 0`.
  - While `lock` is set, `user_in_gated.arrow_keys = 0`.
  - This prevents a held key (for example `RIGHT` on the init page) from cascading through several pages.
- **Precedence:** `rst` overrides everything. A `tick` arriving in ENTER is ignored for request sampling.
- **Reset values:**
  - FSM = RUN, `cur` = INIT (0), `nxt` = 0, `cnt` = 0, `lock` = 0.
  - `page_en` = 1, `page_rst` = 0, `busy` = 0, `req_err` = 0.
  - `prog_out.text` = all spaces, `prog_out.state` = INIT.

## Timing
- `prog_out` lags `page_out[cur].text` by 1 `clk` in RUN.
- Transition latency from the request `tick` (transition *T*) to `cur` updating:
  - BLANK is entered at *T*+1 `clk`.
  - ENTER follows the `BLANK_TICKS`-th subsequent `tick`.
  - `cur` and `page_en` update at the end of the ENTER cycle.
  - `prog_out` shows the new page's text 1 `clk` after returning to RUN.
- `req_err` is asserted in the `clk` after the offending `tick`.
- `user_in_gated` is combinational from `user_in` and `lock`, so it has zero latency.
- `rst` asserted mid-BLANK: the next cycle is RUN on INIT with no `page_rst` pulse, and `lock` is cleared.

## Configuration
- Macro `PAGE_ARB_BLANK_EN`.
- **Defined:** the BLANK phase operates as described above.
- **Undefined:** RUN goes directly to ENTER on an accepted request, with no blank text.
  - `busy` is high for exactly 1 `clk`.
  - `BLANK_TICKS` is ignored.
  - Lockout behaviour is unchanged.

## Test plan
- **Reset:** hold `rst` for 2 `clk`. Expect `prog_out.state` = INIT, text all spaces, `page_en` = 5'b00001, `busy` = 0.
- **Normal transition:** page 0 requests MENU (1) on a `tick`, with `BLANK_TICKS` = 4. Expect:
  - `busy` rises the next `clk`.
  - Blank text for 4 ticks.
  - A `page_rst` = 5'b00010 pulse of 1 `clk`.
  - `page_en` = 5'b00010.
  - Menu text appears 1 `clk` later.
- **Lockout:** hold `user_in.arrow_keys` = `RIGHT` throughout the transition. Expect:
  - `user_in_gated.arrow_keys` = 0 until a `tick` occurs with keys released.
  - After that, `RIGHT` passes through.
- **Illegal request:** page 0 requests state 7 with `NUM_PAGES` = 5. Expect:
  - A `req_err` pulse of 1 `clk`.
  - `cur` stays 0; `busy` stays 0.
- **Reset mid-transition:** assert `rst` during BLANK, after 2 ticks. Expect:
  - Reset values the next `clk`.
  - No `page_rst` pulse.
  - A subsequent request works normally.
- **Macro undefined:** repeat the normal-transition stimulus. Expect `busy` high for 1 `clk`, with no blank ticks.
